// File: rtl/mdr_load_unit.sv
// Load unit: captures an aligned, sign/zero-extended memory read result and holds it until acknowledged.
// Optional WAIT timeout is enabled by defining MDR_TIMEOUT_EN.
module mdr_load_unit #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(DATA_W/8)-1:0] req_offset,
  input  logic [1:0]                  req_size,
  input  logic                        req_signed,
  input  logic                        mem_rvalid,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ack,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int OFF_W = $clog2(DATA_W/8);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic [1:0]          eff_size;
  logic [OFF_W-1:0]    eff_off;
  logic [DATA_W-1:0]   lane;
  logic [DATA_W-1:0]   keep;
  logic                sign_bit;
  logic [DATA_W-1:0]   ext;

  // Narrow accesses keep the selected lane and fill the rest with zero or the lane's sign bit.
  always_comb begin
    eff_size = (DATA_W == 32 && size_q == 2'd3) ? 2'd2 : size_q;
    eff_off  = off_q & ({OFF_W{1'b1}} << eff_size);
    lane     = mem_rdata >> {eff_off, 3'b000};
    keep     = '1;
    sign_bit = lane[DATA_W-1];
    case (eff_size)
      2'd0: begin keep = DATA_W'(8'hFF);         sign_bit = lane[7];  end
      2'd1: begin keep = DATA_W'(16'hFFFF);      sign_bit = lane[15]; end
      2'd2: begin keep = DATA_W'(32'hFFFF_FFFF); sign_bit = lane[31]; end
      default: begin keep = '1;                  sign_bit = lane[DATA_W-1]; end
    endcase
    ext = (lane & keep) | ({DATA_W{sgn_q & sign_bit}} & ~keep);
  end

`ifdef MDR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef MDR_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d   = req_offset;
          size_d  = req_size;
          sgn_d   = req_signed;
          state_d = S_WAIT;
`ifdef MDR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          out_data_d  = ext;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
`ifdef MDR_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Last permitted WAIT edge passed with no data: deliver a zero result flagged as an error.
          out_data_d  = '0;
          out_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_HOLD: begin
        if (out_ack) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
`ifdef MDR_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef MDR_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef MDR_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
`ifdef MDR_TIMEOUT_EN
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_load_unit.sv
// Self-checking bench for mdr_load_unit: a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
// Timeout scenarios are exercised when MDR_TIMEOUT_EN is defined.
module tb_mdr_load_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_signed, mem_rvalid, out_ack;
  logic [1:0]  req_offset, req_size;
  logic [31:0] mem_rdata;
  logic        req_ready, out_valid, busy, timeout_err;
  logic [31:0] out_data;

  logic        w_req_valid, w_req_signed, w_mem_rvalid, w_out_ack;
  logic [2:0]  w_req_offset;
  logic [1:0]  w_req_size;
  logic [63:0] w_mem_rdata;
  logic        w_req_ready, w_out_valid, w_busy, w_timeout_err;
  logic [63:0] w_out_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mdr_load_unit #(.DATA_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_offset(req_offset), .req_size(req_size), .req_signed(req_signed),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ack(out_ack), .busy(busy), .timeout_err(timeout_err)
  );

  mdr_load_unit #(.DATA_W(64), .TIMEOUT(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_offset(w_req_offset), .req_size(w_req_size), .req_signed(w_req_signed),
    .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata), .out_data(w_out_data),
    .out_valid(w_out_valid), .out_ack(w_out_ack), .busy(w_busy), .timeout_err(w_timeout_err)
  );

  // Present a request for one cycle; returns #1 after the accepting edge.
  task automatic start_req(input logic [1:0] off, input logic [1:0] size, input logic sgn);
    @(posedge clk); #1;
    req_valid = 1'b1; req_offset = off; req_size = size; req_signed = sgn;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    mem_rvalid = 1'b1; mem_rdata = data;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    w_req_valid = 1'b1; w_mem_rvalid = 1'b1; w_mem_rdata = '1;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; req_valid = 1'b0; mem_rvalid = 1'b0; w_req_valid = 1'b0; w_mem_rvalid = 1'b0;
    // Check while still in the first post-reset cycle.
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    n_checks++; if (w_out_data !== 64'h0 || w_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_64: got data %h valid %b expected 0/0", w_out_data, w_out_valid); end
  endtask

  typedef struct {
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] data;
    logic [31:0] exp;
  } case_t;

  task automatic test_extract();
    case_t cs[9];
    bit ok;
    logic [63:0] e;
    cs[0] = '{2'd3, 2'd0, 1'b1, 32'h80FF_1234, 32'hFFFF_FF80};
    cs[1] = '{2'd3, 2'd0, 1'b0, 32'h80FF_1234, 32'h0000_0080};
    cs[2] = '{2'd2, 2'd1, 1'b1, 32'h8001_7FFF, 32'hFFFF_8001};
    cs[3] = '{2'd3, 2'd1, 1'b1, 32'h8001_7FFF, 32'hFFFF_8001};
    cs[4] = '{2'd1, 2'd2, 1'b1, 32'h8001_7FFF, 32'h8001_7FFF};
    cs[5] = '{2'd0, 2'd1, 1'b0, 32'h8001_7FFF, 32'h0000_7FFF};
    cs[6] = '{2'd0, 2'd0, 1'b1, 32'h8001_7FFF, 32'hFFFF_FFFF};
    cs[7] = '{2'd2, 2'd3, 1'b1, 32'h8001_7FFF, 32'h8001_7FFF};
    cs[8] = '{2'd1, 2'd0, 1'b1, 32'h8001_7FFF, 32'h0000_007F};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({32'h0, cs[i].exp});
      start_req(cs[i].off, cs[i].size, cs[i].sgn);
      @(negedge clk);
      n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL wait_state_%0d: got busy %b ready %b valid %b expected 1/0/0", i, busy, req_ready, out_valid); end
      @(posedge clk); #1;
      respond(cs[i].data);
      wait_valid(1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL latency_%0d: got out_valid 0 expected 1", i); end
      e = exp_q.pop_front();
      n_checks++; if ({32'h0, out_data} !== e) begin n_fail++; $display("[TB] FAIL extract_%0d: got %h expected %h", i, out_data, e[31:0]); end
      do_ack();
    end
  endtask

  task automatic test_hold_back_to_back();
    bit ok;
    logic [63:0] e;
    exp_q.push_back(64'h1234_5678);
    start_req(2'd0, 2'd2, 1'b0);
    respond(32'h1234_5678);
    wait_valid(4, ok);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL hold_entry: got out_valid 0 expected 1"); end
    req_valid = 1'b1; req_offset = 2'd1; req_size = 2'd0; req_signed = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if ({32'h0, out_data} !== e || out_valid !== 1'b1 || req_ready !== 1'b0) begin
        n_fail++; $display("[TB] FAIL hold_stable_%0d: got data %h valid %b ready %b expected %h/1/0", i, out_data, out_valid, req_ready, e[31:0]); end
    end
    exp_q.push_back(64'h0000_00BE);
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ack_release: got ready %b valid %b expected 1/0", req_ready, out_valid); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++; if (out_valid !== 1'b1 || {32'h0, out_data} !== e) begin
      n_fail++; $display("[TB] FAIL back_to_back: got valid %b data %h expected 1/%h", out_valid, out_data, e[31:0]); end
    do_ack();
  endtask

`ifdef MDR_TIMEOUT_EN
  task automatic test_timeout();
    logic [63:0] e;
    start_req(2'd0, 2'd2, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_early: got valid %b expected 0", out_valid); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || timeout_err !== 1'b1 || out_data !== 32'h0) begin
      n_fail++; $display("[TB] FAIL timeout_fire: got valid %b err %b data %h expected 1/1/0", out_valid, timeout_err, out_data); end
    do_ack();
    @(negedge clk);
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_clear: got %b expected 0", timeout_err); end
    exp_q.push_back(64'h0000_00AB);
    start_req(2'd0, 2'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_00AB;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++; if (out_valid !== 1'b1 || timeout_err !== 1'b0 || {32'h0, out_data} !== e) begin
      n_fail++; $display("[TB] FAIL timeout_data_wins: got valid %b err %b data %h expected 1/0/%h", out_valid, timeout_err, out_data, e[31:0]); end
    do_ack();
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    logic [63:0] e;
    exp_q.push_back(64'hFFFF_FFA5);
    start_req(2'd2, 2'd0, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL wait_persists: got valid %b busy %b err %b expected 0/1/0", out_valid, busy, timeout_err); end
    @(posedge clk); #1;
    respond(32'h00A5_0000);
    wait_valid(1, ok);
    e = exp_q.pop_front();
    n_checks++; if (!ok || {32'h0, out_data} !== e || timeout_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL late_data: got valid %b data %h err %b expected 1/%h/0", ok, out_data, timeout_err, e[31:0]); end
    do_ack();
  endtask
`endif

  task automatic test_reset_abort();
    start_req(2'd0, 2'd2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    respond(32'h5555_AAAA);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_abort: got valid %b busy %b ready %b expected 0/0/1", out_valid, busy, req_ready); end
  endtask

  task automatic test_dword64();
    logic [2:0]  offs[4]  = '{3'd0, 3'd4, 3'd6, 3'd7};
    logic [1:0]  sizes[4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    logic        sgns[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [63:0] exps[4]  = '{64'h8123_4567_89AB_CDEF, 64'hFFFF_FFFF_8123_4567,
                              64'h0000_0000_0000_8123, 64'hFFFF_FFFF_FFFF_FF81};
    logic [63:0] e;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exps[i]);
      @(posedge clk); #1;
      w_req_valid = 1'b1; w_req_offset = offs[i]; w_req_size = sizes[i]; w_req_signed = sgns[i];
      @(posedge clk); #1;
      w_req_valid = 1'b0; w_mem_rvalid = 1'b1; w_mem_rdata = 64'h8123_4567_89AB_CDEF;
      @(posedge clk); #1;
      w_mem_rvalid = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (w_out_valid) begin ok = 1'b1; break; end
      end
      e = exp_q.pop_front();
      n_checks++; if (!ok || w_out_data !== e) begin
        n_fail++; $display("[TB] FAIL load64_%0d: got valid %b data %h expected 1/%h", i, ok, w_out_data, e); end
      w_out_ack = 1'b1;
      @(posedge clk); #1;
      w_out_ack = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_offset = '0; req_size = '0; req_signed = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; out_ack = 1'b0;
    w_req_valid = 1'b0; w_req_offset = '0; w_req_size = '0; w_req_signed = 1'b0;
    w_mem_rvalid = 1'b0; w_mem_rdata = '0; w_out_ack = 1'b0;
    test_reset();
    test_extract();
    test_hold_back_to_back();
`ifdef MDR_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_abort();
    test_dword64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
